// File: rtl/position_sequencer_if.sv
// Command channel of the position sequencer: valid/ready handshake carrying
// an opcode and a step count or load value.
interface position_sequencer_if #(
    parameter int WIDTH = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/position_sequencer.sv
// Command-driven position register: HOLD/UP/DOWN/LOAD stepped one unit per clock
// through ripple-carry arithmetic, with a one-hot select for the position mux.
module position_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    position_sequencer_if.slave  cmd,
    output logic [WIDTH-1:0]     pos,
    output logic [3:0]           sel,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    localparam logic [3:0] SEL_HOLD = 4'b0001;

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] data_q;
    logic             ready_q;

    // Chain of full adders; the carry out of the top bit is returned as the MSB.
    function automatic logic [WIDTH:0] ripple_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin
    );
        logic             c;
        logic [WIDTH-1:0] s;
        c = cin;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    function automatic logic [3:0] op_sel(input op_t op);
        logic [3:0] s;
        case (op)
            OP_UP:   s = 4'b0010;
            OP_DOWN: s = 4'b0100;
            OP_LOAD: s = 4'b1000;
            default: s = 4'b0001;
        endcase
        return s;
    endfunction

    logic [WIDTH-1:0] pos_inc;
    logic             inc_carry;
    logic [WIDTH-1:0] pos_dec;
    logic             dec_carry;
    logic [WIDTH-1:0] cnt_next;
    logic             cnt_carry_unused;

    // Decrement is addition of all-ones; a missing carry out means 0 went to all-ones.
    assign {inc_carry, pos_inc}         = ripple_add(pos, '0, 1'b1);
    assign {dec_carry, pos_dec}         = ripple_add(pos, '1, 1'b0);
    assign {cnt_carry_unused, cnt_next} = ripple_add(cnt, '1, 1'b0);

    assign cmd.cmd_ready = ready_q;

    always_ff @(posedge clk) begin
        if (state == IDLE && cmd.cmd_valid) begin
            data_q <= cmd.cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_HOLD;
            cnt     <= '0;
            pos     <= '0;
            sel     <= SEL_HOLD;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q    <= op_t'(cmd.cmd_op);
                        wrap    <= 1'b0;
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        // Zero-length moves finish without visiting EXEC.
                        if (op_t'(cmd.cmd_op) == OP_HOLD ||
                            (op_t'(cmd.cmd_op) != OP_LOAD && cmd.cmd_data == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            sel   <= SEL_HOLD;
                        end else begin
                            state <= EXEC;
                            sel   <= op_sel(op_t'(cmd.cmd_op));
                            cnt   <= (op_t'(cmd.cmd_op) == OP_LOAD) ? WIDTH'(1) : cmd.cmd_data;
                        end
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_UP: begin
                            pos  <= pos_inc;
                            wrap <= wrap | inc_carry;
                        end
                        OP_DOWN: begin
                            pos  <= pos_dec;
                            wrap <= wrap | ~dec_carry;
                        end
                        OP_LOAD: pos <= data_q;
                        default: ;
                    endcase
                    cnt <= cnt_next;
                    if (cnt == WIDTH'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        sel   <= SEL_HOLD;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                    sel     <= SEL_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_position_sequencer.sv
// Bench for position_sequencer: vector table plus hand-built sequences, with
// completions checked against a queue of expected results.
module tb_position_sequencer;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pos;
    logic [3:0]   sel;
    logic         busy;
    logic         done;
    logic         wrap;

    position_sequencer_if #(.WIDTH(W)) bus ();

    position_sequencer #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cmd  (bus.slave),
        .pos  (pos),
        .sel  (sel),
        .busy (busy),
        .done (done),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    exp_pos;
        int    exp_wrap;
        int    exp_lat;
        int    acc;
    } sb_t;

    typedef struct {
        logic [1:0] op;
        int         data;
        int         exp_sel;
        int         exp_pos;
        int         exp_wrap;
        int         exp_lat;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[12];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_seen = 0;
    int   busy_cnt  = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Completion monitor: every done pulse must match the oldest queued command.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy) busy_cnt++;
                if (done) begin
                    done_seen++;
                    check("done_expected", int'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check({e.name, "_pos"}, int'(pos), e.exp_pos);
                        check({e.name, "_wrap"}, int'(wrap), e.exp_wrap);
                        check({e.name, "_latency"}, cyc - e.acc, e.exp_lat);
                        check({e.name, "_busy_cycles"}, busy_cnt, e.exp_lat + 1);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input int data, input bit hold_valid, output int acc);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = W'(data);
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                if (!hold_valid) bus.cmd_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("accept_in_budget", int'(acc >= 0), 1);
    endtask

    task automatic expect_done(input string name, input int p, input int w, input int lat, input int acc);
        sb_t e;
        e.name     = name;
        e.exp_pos  = p;
        e.exp_wrap = w;
        e.exp_lat  = lat;
        e.acc      = acc;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((sb_q.size() != 0 || !bus.cmd_ready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain"}, int'(k < 100), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, acc2, ds;
        int seq_pos[4];
        int seq_wrap[4];
        int b2b_acc[4];

        vecs[0]  = '{2'b11, 6, 8, 6, 0, 1};
        vecs[1]  = '{2'b01, 3, 2, 1, 1, 3};
        vecs[2]  = '{2'b10, 2, 4, 7, 1, 2};
        vecs[3]  = '{2'b01, 0, 1, 7, 0, 0};
        vecs[4]  = '{2'b00, 5, 1, 7, 0, 0};
        vecs[5]  = '{2'b10, 3, 4, 4, 0, 3};
        vecs[6]  = '{2'b01, 7, 2, 3, 1, 7};
        vecs[7]  = '{2'b11, 0, 8, 0, 0, 1};
        vecs[8]  = '{2'b10, 7, 4, 1, 1, 7};
        vecs[9]  = '{2'b01, 2, 2, 3, 0, 2};
        vecs[10] = '{2'b11, 7, 8, 7, 0, 1};
        vecs[11] = '{2'b01, 1, 2, 0, 1, 1};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pos", int'(pos), 0);
        check("rst_sel", int'(sel), 1);
        check("rst_ready", int'(bus.cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wrap", int'(wrap), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven commands, each run to completion.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].op, vecs[i].data, 1'b0, acc);
            expect_done($sformatf("vec%0d", i), vecs[i].exp_pos, vecs[i].exp_wrap, vecs[i].exp_lat, acc);
            @(negedge clk);
            check($sformatf("vec%0d_sel", i), int'(sel), vecs[i].exp_sel);
            check($sformatf("vec%0d_busy", i), int'(busy), 1);
            check($sformatf("vec%0d_ready", i), int'(bus.cmd_ready), 0);
            wait_idle($sformatf("vec%0d", i));
        end

        repeat (3) @(negedge clk);
        check("wrap_sticky_idle", int'(wrap), 1);

        // LOAD 6 then UP 3, stepping through the wrap cycle by cycle.
        send(2'b11, 6, 1'b0, acc);
        expect_done("load6", 6, 0, 1, acc);
        @(negedge clk);
        check("wrap_cleared_on_accept", int'(wrap), 0);
        wait_idle("load6");
        seq_pos  = '{6, 7, 0, 1};
        seq_wrap = '{0, 0, 1, 1};
        send(2'b01, 3, 1'b0, acc);
        expect_done("up3", 1, 1, 3, acc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("up3_pos_e%0d", k), int'(pos), seq_pos[k]);
            check($sformatf("up3_wrap_e%0d", k), int'(wrap), seq_wrap[k]);
            check($sformatf("up3_sel_e%0d", k), int'(sel), (k < 3) ? 2 : 1);
        end
        wait_idle("up3");

        // DOWN 2 from 1: 0 then 7, ready back after E3.
        send(2'b10, 2, 1'b0, acc);
        expect_done("down2", 7, 1, 2, acc);
        @(negedge clk);
        check("down2_sel", int'(sel), 4);
        @(negedge clk);
        check("down2_pos_e1", int'(pos), 0);
        check("down2_wrap_e1", int'(wrap), 0);
        @(negedge clk);
        check("down2_pos_e2", int'(pos), 7);
        check("down2_ready_e2", int'(bus.cmd_ready), 0);
        @(negedge clk);
        check("down2_ready_e3", int'(bus.cmd_ready), 1);
        wait_idle("down2");

        // LOAD 4 offered while UP 7 runs must wait for ready.
        send(2'b11, 2, 1'b0, acc);
        expect_done("load2", 2, 0, 1, acc);
        wait_idle("load2");
        send(2'b01, 7, 1'b1, acc1);
        expect_done("stall_up7", 1, 1, 7, acc1);
        send(2'b11, 4, 1'b0, acc2);
        expect_done("stall_load4", 4, 0, 1, acc2);
        check("stall_spacing", acc2 - acc1, 9);
        wait_idle("stall");

        // Valid held high across alternating UP 1 / DOWN 1.
        for (int k = 0; k < 4; k++) begin
            send((k % 2 == 0) ? 2'b01 : 2'b10, 1, (k < 3) ? 1'b1 : 1'b0, acc);
            b2b_acc[k] = acc;
            expect_done($sformatf("b2b%0d", k), (k % 2 == 0) ? 5 : 4, 0, 1, acc);
        end
        for (int k = 1; k < 4; k++) begin
            check($sformatf("b2b_spacing%0d", k), b2b_acc[k] - b2b_acc[k-1], 3);
        end
        wait_idle("b2b");

        // Asynchronous reset in the middle of UP 5.
        send(2'b01, 5, 1'b0, acc);
        repeat (3) @(negedge clk);
        check("midup_pos_e2", int'(pos), 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pos", int'(pos), 0);
        check("midrst_sel", int'(sel), 1);
        check("midrst_ready", int'(bus.cmd_ready), 1);
        check("midrst_done", int'(done), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_wrap", int'(wrap), 0);
        busy_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ds = done_seen;
        repeat (8) @(negedge clk);
        check("no_done_after_reset", done_seen - ds, 0);
        check("pos_after_reset", int'(pos), 0);

        send(2'b00, 5, 1'b0, acc);
        expect_done("hold_after_reset", 0, 0, 0, acc);
        wait_idle("hold_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
